ctl_settings_reader: RTL and testbench

Sequencer on the FPGA side of the controller BRAM; the CPU writes this region through the EtherCAT-side port. It polls the control-flag word and, on each new set request, burst-reads the modulation or silencer register block. It latches the values into output registers and pulses an update strobe. It also writes the FPGA state word back into the same BRAM so the CPU can read it.

---
 rtl/ctl_settings_reader.sv | 214 +++++++++++++++++++++
 tb/tb_ctl_settings_reader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ctl_settings_reader.sv
// Controller-BRAM sequencer: polls the ctl-flag word, burst-reads the modulation/silencer
// blocks on SET-bit rising edges, and (with AUTD3_FPGA_STATE_WRITEBACK_EN) writes back the state word.
module ctl_settings_reader #(
  parameter int BRAM_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        BRAM_EN,
  output logic        BRAM_WE,
  output logic [7:0]  BRAM_ADDR,
  output logic [15:0] BRAM_DIN,
  input  logic [15:0] BRAM_DOUT,
  input  logic [6:0]  STATE_IN,
  output logic [3:0]  GPIO_IN,
  output logic        FORCE_FAN,
  output logic        MOD_REQ_RD_SEGMENT,
  output logic [15:0] MOD_CYCLE0,
  output logic [15:0] MOD_CYCLE1,
  output logic [31:0] MOD_FREQ_DIV0,
  output logic [31:0] MOD_FREQ_DIV1,
  output logic [31:0] MOD_REP0,
  output logic [31:0] MOD_REP1,
  output logic [7:0]  MOD_TRANSITION_MODE,
  output logic [63:0] MOD_TRANSITION_VALUE,
  output logic        MOD_UPDATE,
  output logic        SILENCER_MODE,
  output logic [15:0] SILENCER_UPDATE_RATE_INTENSITY,
  output logic [15:0] SILENCER_UPDATE_RATE_PHASE,
  output logic [15:0] SILENCER_COMPLETION_STEPS_INTENSITY,
  output logic [15:0] SILENCER_COMPLETION_STEPS_PHASE,
  output logic        SILENCER_UPDATE
);
  localparam int STAGES = BRAM_LATENCY - 1;

  typedef enum logic [2:0] {RD_FLAG, WAIT_FLAG, EVAL, RD_MOD, RD_SIL, DRAIN, WB_STATE} state_t;

  state_t state;
  logic [1:0] cnt;
  logic prev_mod, prev_sil, sil_pend;
  logic mod_req, sil_req;

  logic [STAGES:0]      vld_pipe;
  logic [STAGES:0][7:0] addr_pipe;
  logic        rd_vld, mod_hit, sil_hit;
  logic [7:0]  rd_addr;
  logic [3:0]  mod_off;
  logic [2:0]  sil_off;
  logic [15:0] mod_sh [16];
  logic [15:0] mod_nx [16];
  logic [15:0] sil_sh [5];
  logic [15:0] sil_nx [5];

  // The flag word is consumed straight off BRAM_DOUT in EVAL, which is when it becomes valid.
  assign mod_req = BRAM_DOUT[0] & ~prev_mod;
  assign sil_req = BRAM_DOUT[2] & ~prev_sil;

  assign rd_vld  = vld_pipe[STAGES];
  assign rd_addr = addr_pipe[STAGES];
  assign mod_off = rd_addr[3:0] - 4'h1;
  assign sil_off = rd_addr[2:0];
  assign mod_hit = rd_vld && rd_addr >= 8'h21 && rd_addr <= 8'h30;
  assign sil_hit = rd_vld && rd_addr >= 8'h40 && rd_addr <= 8'h44;

`ifndef AUTD3_FPGA_STATE_WRITEBACK_EN
  logic unused_state;
  assign unused_state = ^STATE_IN;
  assign BRAM_WE  = 1'b0;
  assign BRAM_DIN = 16'h0000;
`endif

  // Issued-read address pipeline aligned with the BRAM latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= BRAM_EN & ~BRAM_WE;
      addr_pipe[0] <= BRAM_ADDR;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  always_comb begin
    mod_nx = mod_sh;
    sil_nx = sil_sh;
    if (mod_hit) mod_nx[mod_off] = BRAM_DOUT;
    if (sil_hit) sil_nx[sil_off] = BRAM_DOUT;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) mod_sh[i] <= '0;
      for (int i = 0; i < 5; i++)  sil_sh[i] <= '0;
    end else begin
      mod_sh <= mod_nx;
      sil_sh <= sil_nx;
    end
  end

  // Outputs load from the merged shadow as the block's last word lands, so no partial block shows.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MOD_REQ_RD_SEGMENT <= 1'b0; MOD_CYCLE0 <= '0; MOD_CYCLE1 <= '0;
      MOD_FREQ_DIV0 <= '0; MOD_FREQ_DIV1 <= '0; MOD_REP0 <= '0; MOD_REP1 <= '0;
      MOD_TRANSITION_MODE <= '0; MOD_TRANSITION_VALUE <= '0; MOD_UPDATE <= 1'b0;
      SILENCER_MODE <= 1'b0; SILENCER_UPDATE_RATE_INTENSITY <= '0; SILENCER_UPDATE_RATE_PHASE <= '0;
      SILENCER_COMPLETION_STEPS_INTENSITY <= '0; SILENCER_COMPLETION_STEPS_PHASE <= '0;
      SILENCER_UPDATE <= 1'b0;
    end else begin
      MOD_UPDATE      <= 1'b0;
      SILENCER_UPDATE <= 1'b0;
      if (mod_hit && rd_addr == 8'h30) begin
        MOD_REQ_RD_SEGMENT   <= mod_nx[0][0];
        MOD_CYCLE0           <= mod_nx[1];
        MOD_FREQ_DIV0        <= {mod_nx[3], mod_nx[2]};
        MOD_CYCLE1           <= mod_nx[4];
        MOD_FREQ_DIV1        <= {mod_nx[6], mod_nx[5]};
        MOD_REP0             <= {mod_nx[8], mod_nx[7]};
        MOD_REP1             <= {mod_nx[10], mod_nx[9]};
        MOD_TRANSITION_MODE  <= mod_nx[11][7:0];
        MOD_TRANSITION_VALUE <= {mod_nx[15], mod_nx[14], mod_nx[13], mod_nx[12]};
        MOD_UPDATE           <= 1'b1;
      end
      if (sil_hit && rd_addr == 8'h44) begin
        SILENCER_MODE                       <= sil_nx[0][0];
        SILENCER_UPDATE_RATE_INTENSITY      <= sil_nx[1];
        SILENCER_UPDATE_RATE_PHASE          <= sil_nx[2];
        SILENCER_COMPLETION_STEPS_INTENSITY <= sil_nx[3];
        SILENCER_COMPLETION_STEPS_PHASE     <= sil_nx[4];
        SILENCER_UPDATE                     <= 1'b1;
      end
    end
  end

  // BRAM port registers are loaded one state ahead so each issue shows up in its own state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= RD_FLAG; cnt <= '0;
      BRAM_EN <= 1'b0; BRAM_ADDR <= '0;
`ifdef AUTD3_FPGA_STATE_WRITEBACK_EN
      BRAM_WE <= 1'b0; BRAM_DIN <= '0;
`endif
      GPIO_IN <= '0; FORCE_FAN <= 1'b0;
      prev_mod <= 1'b0; prev_sil <= 1'b0; sil_pend <= 1'b0;
    end else begin
      case (state)
        RD_FLAG: begin
          BRAM_EN <= 1'b1; BRAM_ADDR <= 8'h00; cnt <= '0;
          state <= WAIT_FLAG;
        end
        WAIT_FLAG: begin
          BRAM_EN <= 1'b0;
          cnt <= cnt + 2'd1;
          if (cnt == 2'(BRAM_LATENCY - 1)) state <= EVAL;
        end
        EVAL: begin
          GPIO_IN   <= BRAM_DOUT[11:8];
          FORCE_FAN <= BRAM_DOUT[13];
          prev_mod  <= BRAM_DOUT[0];
          prev_sil  <= BRAM_DOUT[2];
          sil_pend  <= sil_req;
          if (mod_req) begin
            BRAM_EN <= 1'b1; BRAM_ADDR <= 8'h21; state <= RD_MOD;
          end else if (sil_req) begin
            BRAM_EN <= 1'b1; BRAM_ADDR <= 8'h40; state <= RD_SIL;
          end else begin
`ifdef AUTD3_FPGA_STATE_WRITEBACK_EN
            BRAM_EN <= 1'b1; BRAM_WE <= 1'b1; BRAM_ADDR <= 8'h01;
            BRAM_DIN <= {8'h00, 1'b1, STATE_IN}; state <= WB_STATE;
`else
            state <= RD_FLAG;
`endif
          end
        end
        RD_MOD: begin
          if (BRAM_ADDR == 8'h30) begin
            cnt <= '0;
            if (sil_pend) begin
              BRAM_ADDR <= 8'h40; state <= RD_SIL;
            end else begin
              BRAM_EN <= 1'b0; state <= DRAIN;
            end
          end else BRAM_ADDR <= BRAM_ADDR + 8'd1;
        end
        RD_SIL: begin
          cnt <= '0;
          if (BRAM_ADDR == 8'h44) begin
            BRAM_EN <= 1'b0; state <= DRAIN;
          end else BRAM_ADDR <= BRAM_ADDR + 8'd1;
        end
        DRAIN: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'(BRAM_LATENCY - 1)) begin
`ifdef AUTD3_FPGA_STATE_WRITEBACK_EN
            BRAM_EN <= 1'b1; BRAM_WE <= 1'b1; BRAM_ADDR <= 8'h01;
            BRAM_DIN <= {8'h00, 1'b1, STATE_IN}; state <= WB_STATE;
`else
            state <= RD_FLAG;
`endif
          end
        end
`ifdef AUTD3_FPGA_STATE_WRITEBACK_EN
        WB_STATE: begin
          BRAM_EN <= 1'b0; BRAM_WE <= 1'b0; state <= RD_FLAG;
        end
`endif
        default: state <= RD_FLAG;
      endcase
    end
  end
endmodule

// File: tb/tb_ctl_settings_reader.sv
// Bench for ctl_settings_reader: BRAM model with CPU side port, randomized flag/block traffic
// checked against a pulse-count and memory-image reference.
module tb_ctl_settings_reader;
  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        BRAM_EN, BRAM_WE;
  logic [7:0]  BRAM_ADDR;
  logic [15:0] BRAM_DIN, BRAM_DOUT;
  logic [6:0]  STATE_IN = 7'h01;
  logic [3:0]  GPIO_IN;
  logic        FORCE_FAN, MOD_REQ_RD_SEGMENT, MOD_UPDATE, SILENCER_MODE, SILENCER_UPDATE;
  logic [15:0] MOD_CYCLE0, MOD_CYCLE1;
  logic [31:0] MOD_FREQ_DIV0, MOD_FREQ_DIV1, MOD_REP0, MOD_REP1;
  logic [7:0]  MOD_TRANSITION_MODE;
  logic [63:0] MOD_TRANSITION_VALUE;
  logic [15:0] SIL_RI, SIL_RP, SIL_CI, SIL_CP;

  ctl_settings_reader #(.BRAM_LATENCY(LAT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR), .BRAM_DIN(BRAM_DIN), .BRAM_DOUT(BRAM_DOUT),
    .STATE_IN(STATE_IN), .GPIO_IN(GPIO_IN), .FORCE_FAN(FORCE_FAN),
    .MOD_REQ_RD_SEGMENT(MOD_REQ_RD_SEGMENT), .MOD_CYCLE0(MOD_CYCLE0), .MOD_CYCLE1(MOD_CYCLE1),
    .MOD_FREQ_DIV0(MOD_FREQ_DIV0), .MOD_FREQ_DIV1(MOD_FREQ_DIV1), .MOD_REP0(MOD_REP0), .MOD_REP1(MOD_REP1),
    .MOD_TRANSITION_MODE(MOD_TRANSITION_MODE), .MOD_TRANSITION_VALUE(MOD_TRANSITION_VALUE),
    .MOD_UPDATE(MOD_UPDATE), .SILENCER_MODE(SILENCER_MODE),
    .SILENCER_UPDATE_RATE_INTENSITY(SIL_RI), .SILENCER_UPDATE_RATE_PHASE(SIL_RP),
    .SILENCER_COMPLETION_STEPS_INTENSITY(SIL_CI), .SILENCER_COMPLETION_STEPS_PHASE(SIL_CP),
    .SILENCER_UPDATE(SILENCER_UPDATE)
  );

  always #5 CLK = ~CLK;

  // BRAM: DUT port plus a CPU write port; read data appears LAT cycles after the issue cycle.
  logic [15:0] mem [256] = '{default: 16'h0000};
  logic [15:0] dl [LAT];
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [15:0] cpu_din = '0;
  always @(posedge CLK) begin
    if (cpu_we) mem[cpu_addr] <= cpu_din;
    if (BRAM_EN && BRAM_WE) mem[BRAM_ADDR] <= BRAM_DIN;
    for (int i = LAT - 1; i > 0; i--) dl[i] <= dl[i-1];
    dl[0] <= (BRAM_EN && !BRAM_WE) ? mem[BRAM_ADDR] : 16'hDEAD;
  end
  assign BRAM_DOUT = dl[LAT-1];

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: count strobes, time them against observed issue cycles, check values against memory.
  int cyc = 0, t21 = 0, t30 = 0, t44 = 0, t_mod = 0, t_sil = 0, n_mod = 0, n_sil = 0;
  always @(negedge CLK) begin
    cyc++;
    if (BRAM_EN && !BRAM_WE) begin
      if (BRAM_ADDR == 8'h21) t21 = cyc;
      if (BRAM_ADDR == 8'h30) t30 = cyc;
      if (BRAM_ADDR == 8'h44) t44 = cyc;
    end
    if (MOD_UPDATE) begin
      n_mod++; t_mod = cyc;
      chk("mod_lat", 64'(cyc - t21), 64'(16 + LAT));
      chk("mod_seg", {63'd0, MOD_REQ_RD_SEGMENT}, {63'd0, mem[8'h21][0]});
      chk("mod_cyc0", {48'd0, MOD_CYCLE0}, {48'd0, mem[8'h22]});
      chk("mod_fdiv0", {32'd0, MOD_FREQ_DIV0}, {32'd0, mem[8'h24], mem[8'h23]});
      chk("mod_cyc1", {48'd0, MOD_CYCLE1}, {48'd0, mem[8'h25]});
      chk("mod_fdiv1", {32'd0, MOD_FREQ_DIV1}, {32'd0, mem[8'h27], mem[8'h26]});
      chk("mod_rep0", {32'd0, MOD_REP0}, {32'd0, mem[8'h29], mem[8'h28]});
      chk("mod_rep1", {32'd0, MOD_REP1}, {32'd0, mem[8'h2B], mem[8'h2A]});
      chk("mod_tmode", {56'd0, MOD_TRANSITION_MODE}, {56'd0, mem[8'h2C][7:0]});
      chk("mod_tval", MOD_TRANSITION_VALUE, {mem[8'h30], mem[8'h2F], mem[8'h2E], mem[8'h2D]});
    end
    if (SILENCER_UPDATE) begin
      n_sil++; t_sil = cyc;
      chk("sil_lat", 64'(cyc - t44), 64'(LAT + 1));
      chk("sil_mode", {63'd0, SILENCER_MODE}, {63'd0, mem[8'h40][0]});
      chk("sil_ri", {48'd0, SIL_RI}, {48'd0, mem[8'h41]});
      chk("sil_rp", {48'd0, SIL_RP}, {48'd0, mem[8'h42]});
      chk("sil_ci", {48'd0, SIL_CI}, {48'd0, mem[8'h43]});
      chk("sil_cp", {48'd0, SIL_CP}, {48'd0, mem[8'h44]});
    end
  end

  task automatic cpu_wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge CLK);
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
    @(negedge CLK);
    cpu_we = 1'b0;
  endtask

  task automatic fill_blocks();
    for (int a = 8'h21; a <= 8'h30; a++) cpu_wr(8'(a), 16'($urandom));
    for (int a = 8'h40; a <= 8'h44; a++) cpu_wr(8'(a), 16'($urandom));
  endtask

  // Reference: one service per 0->1 edge of bit0/bit2 relative to the last flag value seen.
  int exp_mod = 0, exp_sil = 0;
  logic [15:0] old_flag = '0;
  task automatic set_flag(input logic [15:0] v);
    cpu_wr(8'h00, v);
    if (v[0] && !old_flag[0]) exp_mod++;
    if (v[2] && !old_flag[2]) exp_sil++;
    old_flag = v;
    repeat (80) @(negedge CLK);
    chk("mod_count", 64'(n_mod), 64'(exp_mod));
    chk("sil_count", 64'(n_sil), 64'(exp_sil));
    chk("gpio", {60'd0, GPIO_IN}, {60'd0, v[11:8]});
    chk("fan", {63'd0, FORCE_FAN}, {63'd0, v[13]});
`ifdef AUTD3_FPGA_STATE_WRITEBACK_EN
    chk("wb_state", {48'd0, mem[8'h01]}, {48'd0, 8'h00, 1'b1, STATE_IN});
`else
    chk("we_tied", {63'd0, BRAM_WE}, 64'd0);
`endif
  endtask

  initial begin
    logic [15:0] v;
    bit found;
    int saved;
    repeat (5) @(negedge CLK);
    chk("rst_gpio", {60'd0, GPIO_IN}, 64'd0);
    chk("rst_fdiv0", {32'd0, MOD_FREQ_DIV0}, 64'd0);
    chk("rst_tval", MOD_TRANSITION_VALUE, 64'd0);
    chk("rst_sil_ci", {48'd0, SIL_CI}, 64'd0);
    chk("rst_en", {63'd0, BRAM_EN}, 64'd0);
    chk("rst_upd", {62'd0, MOD_UPDATE, SILENCER_UPDATE}, 64'd0);
    RST_N = 1'b1;

    // Idle polling, no request.
    repeat (100) @(negedge CLK);
    chk("idle_mod", 64'(n_mod), 64'd0);
    chk("idle_sil", 64'(n_sil), 64'd0);
`ifdef AUTD3_FPGA_STATE_WRITEBACK_EN
    chk("idle_wb", {48'd0, mem[8'h01]}, 64'h0081);
`endif

    // Directed freq-div value, then bit0 held high.
    fill_blocks();
    cpu_wr(8'h23, 16'h1234);
    cpu_wr(8'h24, 16'h0005);
    set_flag(16'h0001);
    chk("fdiv0_dir", {32'd0, MOD_FREQ_DIV0}, 64'h0005_1234);
    set_flag(16'h0001);
    set_flag(16'h0000);

    // Both requests in one write: modulation first, silencer after the mod burst.
    fill_blocks();
    cpu_wr(8'h43, 16'd10);
    set_flag(16'h0005);
    chk("sil_ci_dir", {48'd0, SIL_CI}, 64'd10);
    chk("sil_after_burst", 64'(t_sil - t30), 64'(LAT + 6));
    chk("sil_after_mod", {63'd0, t_sil > t_mod}, 64'd1);

    // bit2 toggled 1->0->1 gives two services.
    set_flag(16'h0000);
    fill_blocks(); set_flag(16'h0004);
    set_flag(16'h0000);
    fill_blocks(); set_flag(16'h0004);

    // Randomized flag traffic.
    for (int it = 0; it < 10; it++) begin
      fill_blocks();
      STATE_IN = 7'($urandom);
      v = 16'($urandom);
      set_flag(v);
    end

    // GPIO/fan only, no service.
    set_flag(16'h0000);
    saved = n_mod + n_sil;
    set_flag(16'h2F00);
    chk("gpio_no_pulse", 64'(n_mod + n_sil), 64'(saved));

    // Reset mid modulation burst: aborted, then the still-set bit is serviced once after release.
    set_flag(16'h0000);
    fill_blocks();
    cpu_wr(8'h00, 16'h0001);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK);
      if (BRAM_EN && !BRAM_WE && BRAM_ADDR == 8'h25) found = 1'b1;
    end
    chk("burst_seen", {63'd0, found}, 64'd1);
    saved = n_mod;
    RST_N = 1'b0;
    #1;
    chk("abort_fdiv0", {32'd0, MOD_FREQ_DIV0}, 64'd0);
    chk("abort_tval", MOD_TRANSITION_VALUE, 64'd0);
    chk("abort_sil_rp", {48'd0, SIL_RP}, 64'd0);
    chk("abort_gpio", {60'd0, GPIO_IN}, 64'd0);
    repeat (30) @(negedge CLK);
    chk("abort_no_pulse", 64'(n_mod), 64'(saved));
    RST_N = 1'b1;
    old_flag = 16'h0000;
    exp_mod = n_mod;
    set_flag(16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
